// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: bundle of the fetch, data and shared-memory signals
// around the unified memory arbiter.
//   slave  modport: the arbiter. It takes the requests and mem_rdata, and drives
//                   the completion data, the ready pulses, the mem_* port and stall.
//   master modport: the surrounding pipeline and memory, which drive and observe
//                   the same signals from the other side.
interface unified_mem_arbiter_if #(
    parameter int unsigned N = 64
);
    // Fetch path
    logic          if_req;
    logic [N-1:0]  if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    // Data path
    logic          d_read;
    logic          d_write;
    logic [N-1:0]  d_addr;
    logic [N-1:0]  d_wdata;
    logic [N-1:0]  d_rdata;
    logic          d_ready;
    // Shared memory port
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [N-1:0]  mem_rdata;
    // Pipeline freeze
    logic          stall;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_wdata, mem_re,
               mem_we, stall
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_wdata, mem_re,
               mem_we, stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory port between instruction
// fetch and data access. Data requests win over fetch, and only one transaction
// is in flight at a time. Each access holds the memory port for MEM_LATENCY
// cycles. A single DONE cycle follows, in which the matching ready pulses.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - unified_mem_arbiter_if.slave, which carries:
//             fetch request and address, and the 32-bit fetched word with if_ready
//             data read/write request, address, write data, and d_rdata with d_ready
//             shared memory address, write data, enables and read data
//             stall
// MEM_LATENCY must be 1..15; the counter is 4 bits wide.
module unified_mem_arbiter #(
    parameter int unsigned N           = 64,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    unified_mem_arbiter_if.slave   bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] LatCnt = 4'(MEM_LATENCY - 1);

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         op_write_q, op_write_d;
    logic         d_side_q, d_side_d;     // transaction belongs to the data path
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [31:0]  if_rdata_q, if_rdata_d;
    logic [N-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        d_side_d   = d_side_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            StIdle: begin
                if (bus.d_read || bus.d_write) begin
                    // read and write together count as a write
                    state_d    = StBusyD;
                    addr_d     = bus.d_addr;
                    wdata_d    = bus.d_wdata;
                    op_write_d = bus.d_write;
                    d_side_d   = 1'b1;
                    cnt_d      = LatCnt;
                end else if (bus.if_req) begin
                    state_d    = StBusyI;
                    addr_d     = bus.if_addr;
                    wdata_d    = '0;
                    op_write_d = 1'b0;
                    d_side_d   = 1'b0;
                    cnt_d      = LatCnt;
                end
            end
            StBusyI, StBusyD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // mem_rdata is valid in the last busy cycle
                    state_d = StDone;
                    if (state_q == StBusyI) begin
                        if_rdata_d = bus.mem_rdata[31:0];
                    end else if (!op_write_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            StDone: begin
                // no grant here, so a request still held becomes a new transaction
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            d_side_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            d_side_q   <= d_side_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.if_ready  = 1'b0;
        bus.d_ready   = 1'b0;
        case (state_q)
            StBusyI: begin
                bus.mem_addr = addr_q;
                bus.mem_re   = 1'b1;
            end
            StBusyD: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                bus.mem_we    = op_write_q;
                bus.mem_re    = ~op_write_q;
            end
            StDone: begin
                bus.if_ready = ~d_side_q;
                bus.d_ready  = d_side_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    // Held low during reset so the pipeline is not frozen while it resets.
    assign bus.stall = (bus.if_req | bus.d_read | bus.d_write) & (state_q != StDone) & ~reset;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.N(64)) if2 ();
    unified_mem_arbiter_if #(.N(64)) if1 ();

    unified_mem_arbiter #(.N(64), .MEM_LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (if2.slave)
    );

    unified_mem_arbiter #(.N(64), .MEM_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1.slave)
    );

    typedef struct packed {
        logic        is_data;
        logic [63:0] data;
    } sb_t;

    sb_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a ready pulse on the selected DUT (1: latency-1 build), then check
    // the latency, which ready pulsed, and the returned data against the queue head.
    task automatic wait_ready(input bit sel, input int exp_cycles);
        int  n;
        bit  seen;
        sb_t item;
        logic ir, dr;
        n    = 0;
        seen = 1'b0;
        ir   = 1'b0;
        dr   = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            ir = sel ? if1.if_ready : if2.if_ready;
            dr = sel ? if1.d_ready  : if2.d_ready;
            if (ir || dr) seen = 1'b1;
        end
        chk("ready_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("ready_latency", 64'(n), 64'(exp_cycles));
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                item = sb.pop_front();
                chk("ready_kind_d", 64'(dr), 64'(item.is_data));
                chk("ready_kind_if", 64'(ir), 64'(!item.is_data));
                if (item.is_data)
                    chk("d_rdata", sel ? if1.d_rdata : if2.d_rdata, item.data);
                else
                    chk("if_rdata", 64'(sel ? if1.if_rdata : if2.if_rdata), item.data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        if2.if_req = 1'b1; if2.if_addr = '0; if2.d_read = 1'b0; if2.d_write = 1'b0;
        if2.d_addr = '0; if2.d_wdata = '0; if2.mem_rdata = '0;
        if1.if_req = 1'b0; if1.if_addr = '0; if1.d_read = 1'b0; if1.d_write = 1'b0;
        if1.d_addr = '0; if1.d_wdata = '0; if1.mem_rdata = '0;

        // Reset held two cycles with a fetch request pending
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_stall", 64'(if2.stall), 64'd0);
            chk("rst_mem_re", 64'(if2.mem_re), 64'd0);
            chk("rst_mem_we", 64'(if2.mem_we), 64'd0);
            chk("rst_mem_addr", if2.mem_addr, 64'd0);
            chk("rst_if_ready", 64'(if2.if_ready), 64'd0);
            chk("rst_d_ready", 64'(if2.d_ready), 64'd0);
            chk("rst_if_rdata", 64'(if2.if_rdata), 64'd0);
            chk("rst_d_rdata", if2.d_rdata, 64'd0);
        end

        // Fetch from 0x40
        rst = 1'b0;
        if2.if_addr   = 64'h40;
        if2.mem_rdata = 64'h0000_0000_00A0_0093;
        sb.push_back('{is_data: 1'b0, data: 64'h0000_0000_00A0_0093});
        #1;
        chk("f_stall_idle", 64'(if2.stall), 64'd1);
        step();
        chk("f_b1_mem_re", 64'(if2.mem_re), 64'd1);
        chk("f_b1_mem_we", 64'(if2.mem_we), 64'd0);
        chk("f_b1_mem_addr", if2.mem_addr, 64'h40);
        chk("f_b1_mem_wdata", if2.mem_wdata, 64'd0);
        chk("f_b1_stall", 64'(if2.stall), 64'd1);
        wait_ready(1'b0, 2);
        chk("f_done_stall", 64'(if2.stall), 64'd0);
        chk("f_done_mem_re", 64'(if2.mem_re), 64'd0);
        chk("f_done_mem_addr", if2.mem_addr, 64'd0);
        if2.if_req = 1'b0;
        step();
        chk("f_pulse_end", 64'(if2.if_ready), 64'd0);
        chk("f_if_rdata_hold", 64'(if2.if_rdata), 64'h00A0_0093);

        // Simultaneous fetch and data read: data first
        if2.if_req    = 1'b1;
        if2.if_addr   = 64'h80;
        if2.d_read    = 1'b1;
        if2.d_addr    = 64'h100;
        if2.mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        sb.push_back('{is_data: 1'b1, data: 64'hDEAD_BEEF_CAFE_F00D});
        sb.push_back('{is_data: 1'b0, data: 64'h0000_0000_0013_0513});
        step();
        chk("s_mem_addr_d", if2.mem_addr, 64'h100);
        chk("s_mem_re", 64'(if2.mem_re), 64'd1);
        wait_ready(1'b0, 2);
        if2.d_read    = 1'b0;
        if2.mem_rdata = 64'h5555_6666_0013_0513;
        wait_ready(1'b0, 4);
        chk("s_d_rdata_hold", if2.d_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        if2.if_req = 1'b0;
        step();

        // Write: operands latched, d_rdata untouched
        if2.d_write   = 1'b1;
        if2.d_addr    = 64'h8;
        if2.d_wdata   = 64'h1234;
        if2.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        sb.push_back('{is_data: 1'b1, data: 64'hDEAD_BEEF_CAFE_F00D});
        step();
        chk("w_b1_mem_we", 64'(if2.mem_we), 64'd1);
        chk("w_b1_mem_re", 64'(if2.mem_re), 64'd0);
        chk("w_b1_mem_wdata", if2.mem_wdata, 64'h1234);
        chk("w_b1_mem_addr", if2.mem_addr, 64'h8);
        if2.d_wdata = 64'h9999;
        if2.d_addr  = 64'h77;
        step();
        chk("w_b2_mem_we", 64'(if2.mem_we), 64'd1);
        chk("w_b2_mem_wdata", if2.mem_wdata, 64'h1234);
        chk("w_b2_mem_addr", if2.mem_addr, 64'h8);
        wait_ready(1'b0, 1);
        if2.d_write = 1'b0;
        step();
        chk("w_pulse_end", 64'(if2.d_ready), 64'd0);

        // Read and write together act as a write
        if2.d_read  = 1'b1;
        if2.d_write = 1'b1;
        if2.d_addr  = 64'h10;
        if2.d_wdata = 64'hABCD;
        sb.push_back('{is_data: 1'b1, data: 64'hDEAD_BEEF_CAFE_F00D});
        step();
        chk("rw_mem_we", 64'(if2.mem_we), 64'd1);
        chk("rw_mem_re", 64'(if2.mem_re), 64'd0);
        chk("rw_mem_wdata", if2.mem_wdata, 64'hABCD);
        wait_ready(1'b0, 2);
        if2.d_read  = 1'b0;
        if2.d_write = 1'b0;
        step();

        // Reset during the first busy cycle of a read
        if2.d_read    = 1'b1;
        if2.d_addr    = 64'h20;
        if2.mem_rdata = 64'h7777;
        step();
        chk("r_b1_mem_re", 64'(if2.mem_re), 64'd1);
        rst = 1'b1;
        step();
        chk("r_mem_re", 64'(if2.mem_re), 64'd0);
        chk("r_mem_addr", if2.mem_addr, 64'd0);
        chk("r_d_rdata_clr", if2.d_rdata, 64'd0);
        chk("r_stall", 64'(if2.stall), 64'd0);
        rst = 1'b0;
        if2.d_read = 1'b0;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (if2.d_ready || if2.mem_re) hits++;
        end
        chk("r_no_ready", 64'(hits), 64'd0);

        // Latency-1 build: request dropped in the busy cycle
        if1.d_read    = 1'b1;
        if1.d_addr    = 64'h30;
        if1.mem_rdata = 64'h0123_4567_89AB_CDEF;
        sb.push_back('{is_data: 1'b1, data: 64'h0123_4567_89AB_CDEF});
        step();
        chk("l1_mem_re", 64'(if1.mem_re), 64'd1);
        if1.d_read = 1'b0;
        if1.d_addr = 64'h99;
        #1;
        chk("l1_mem_addr_held", if1.mem_addr, 64'h30);
        wait_ready(1'b1, 1);
        step();
        chk("l1_pulse_end", 64'(if1.d_ready), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
